// File: rtl/pkt_switch_pkg.sv
// ---------------------------------------------------------------------------
// pkt_switch_pkg
// Shared types and helpers for the packet switch arbiters.
//   sched_state_t   : egress scheduler state (IDLE / SEND / HOLD)
//   ports_for_width : number of ports addressable by an index of given width;
//                     a port count must equal ports_for_width(IDX_WIDTH)
// ---------------------------------------------------------------------------
package pkt_switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  function automatic int unsigned ports_for_width(input int unsigned idx_width);
    return 32'd1 << idx_width;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating priority encoder. Scans req starting at ptr and
// moving upward (index wraps by truncation) and returns the first set bit.
// Ports:
//   req   in  N_PORTS    request vector
//   ptr   in  IDX_WIDTH  highest-priority index
//   found out 1          at least one request set
//   idx   out IDX_WIDTH  winning index (ptr when nothing found)
// ---------------------------------------------------------------------------
module rr_priority_pick
  import pkt_switch_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [N_PORTS-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  // The scan covers every value the index can take, so req must be exactly
  // that wide for the rotation to be fair.
  localparam int SCAN_LEN = ports_for_width(IDX_WIDTH);

  logic [IDX_WIDTH-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = SCAN_LEN - 1; k >= 0; k--) begin
      cand = ptr + IDX_WIDTH'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_packet_scheduler.sv
// ---------------------------------------------------------------------------
// wrr_packet_scheduler
// Per-egress packet-granular weighted round-robin scheduler. Picks among
// ingresses whose head packet targets this egress; a winner may send up to
// weight consecutive packets before the round-robin pointer moves past it.
// A stall watchdog reclaims the egress from an ingress that goes quiet
// mid-packet while the egress is ready.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ingress_valid/last/dst   per-ingress beat valid, last beat, destination
//   egress_port_id    static ID of this egress
//   egress_ready      egress accepts a beat
//   weight_cfg        per-ingress packet quota (0 disables the ingress)
//   cfg_load          latch weight_cfg on the next edge
//   timeout_cycles    watchdog limit (0 disables)
//   selected_ingress  crossbar select (registered)
//   egress_valid/last beat towards the egress
//   ingress_ready     ready back to the owning ingress only
//   grant             registered one-hot owner, zero when idle
//   busy              scheduler not idle
//   timeout_evt       one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module wrr_packet_scheduler
  import pkt_switch_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int IDX_WIDTH     = 2,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_PORTS-1:0]       ingress_valid,
  input  logic [N_PORTS-1:0]       ingress_last,
  input  logic [IDX_WIDTH-1:0]     ingress_dst [N_PORTS],
  input  logic [IDX_WIDTH-1:0]     egress_port_id,
  input  logic                     egress_ready,
  input  logic [WEIGHT_WIDTH-1:0]  weight_cfg [N_PORTS],
  input  logic                     cfg_load,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic [IDX_WIDTH-1:0]     selected_ingress,
  output logic                     egress_valid,
  output logic                     egress_last,
  output logic [N_PORTS-1:0]       ingress_ready,
  output logic [N_PORTS-1:0]       grant,
  output logic                     busy,
  output logic                     timeout_evt
);

  sched_state_t             state_reg, state_next;
  logic [IDX_WIDTH-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IDX_WIDTH-1:0]     select_reg, select_next;
  logic [N_PORTS-1:0]       grant_reg, grant_next;
  logic [WEIGHT_WIDTH-1:0]  credit_reg, credit_next;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
  logic [WEIGHT_WIDTH-1:0]  weight_reg [N_PORTS];

  logic [N_PORTS-1:0]       eligible;
  logic                     pick_found;
  logic [IDX_WIDTH-1:0]     pick_idx;
  logic [IDX_WIDTH-1:0]     select_inc;
  logic [TIMEOUT_WIDTH-1:0] stall_inc;
  logic                     sel_valid;
  logic                     sel_last;
  logic                     timeout_hit;

  // Per-ingress eligibility and weight registers.
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign eligible[gi] = ingress_valid[gi]
                          && (ingress_dst[gi] == egress_port_id)
                          && (weight_reg[gi] != '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          weight_reg[gi] <= WEIGHT_WIDTH'(1);
        end else if (cfg_load) begin
          weight_reg[gi] <= weight_cfg[gi];
        end
      end
    end
  endgenerate

  rr_priority_pick #(
    .N_PORTS   (N_PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_valid   = ingress_valid[select_reg];
  assign sel_last    = ingress_last[select_reg];
  assign select_inc  = select_reg + IDX_WIDTH'(1);
  assign stall_inc   = stall_cnt_reg + TIMEOUT_WIDTH'(1);
  // Fires on the stall cycle that would bring the count up to the limit.
  assign timeout_hit = (timeout_cycles != '0) && (stall_inc == timeout_cycles);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      select_reg    <= '0;
      grant_reg     <= '0;
      credit_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      select_reg    <= select_next;
      grant_reg     <= grant_next;
      credit_reg    <= credit_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    select_next    = select_reg;
    grant_next     = grant_reg;
    credit_next    = credit_reg;
    stall_cnt_next = stall_cnt_reg;
    egress_valid   = 1'b0;
    egress_last    = 1'b0;
    ingress_ready  = '0;
    timeout_evt    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next  = SEND;
          select_next = pick_idx;
          grant_next  = N_PORTS'(1) << pick_idx;
          // Eligible implies a non-zero weight, so this cannot underflow.
          credit_next = weight_reg[pick_idx] - WEIGHT_WIDTH'(1);
        end
      end

      SEND: begin
        egress_valid              = sel_valid;
        egress_last               = sel_valid && sel_last;
        ingress_ready[select_reg] = egress_ready;

        if (sel_valid && egress_ready) begin
          stall_cnt_next = '0;
          if (sel_last) begin
            if (credit_reg != '0) begin
              credit_next = credit_reg - WEIGHT_WIDTH'(1);
              state_next  = HOLD;
            end else begin
              rr_ptr_next = select_inc;
              grant_next  = '0;
              state_next  = IDLE;
            end
          end
        end else if (egress_ready) begin
          // Source starved while the egress could take a beat. Backpressure
          // from the egress alone never reaches this branch.
          if (timeout_hit) begin
            timeout_evt    = 1'b1;
            rr_ptr_next    = select_inc;
            grant_next     = '0;
            stall_cnt_next = '0;
            state_next     = IDLE;
          end else begin
            stall_cnt_next = stall_inc;
          end
        end
      end

      HOLD: begin
        // One bubble between packets of the same grant; the owner keeps the
        // egress only if its next packet is already waiting.
        if (eligible[select_reg]) begin
          state_next = SEND;
        end else begin
          rr_ptr_next = select_inc;
          grant_next  = '0;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    // Ownership is dropped as soon as reset is seen, not one edge later.
    if (reset) begin
      egress_valid  = 1'b0;
      egress_last   = 1'b0;
      ingress_ready = '0;
      timeout_evt   = 1'b0;
    end
  end

  assign selected_ingress = select_reg;
  assign grant            = grant_reg;
  assign busy             = !reset && (state_reg != IDLE);

endmodule

// File: doc/wrr_packet_scheduler.md
Name: wrr_packet_scheduler

Overview:
Per-egress packet-granular weighted round-robin scheduler for the packet switch; one instance per egress port drives that port's crossbar mux select. Arbitrates among ingress ports whose head packet targets this egress. Each grant lets the winner send up to `weight` consecutive packets before the pointer advances. A stall watchdog reclaims the egress from an ingress that stops mid-packet.

Parameters:
N_PORTS, 4, number of ingress ports; must equal 2**IDX_WIDTH
IDX_WIDTH, 2, width of port index
WEIGHT_WIDTH, 4, width of per-ingress packet quota
TIMEOUT_WIDTH, 8, width of stall watchdog limit

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
ingress_valid  in  N_PORTS  per-ingress beat valid
ingress_last  in  N_PORTS  per-ingress last beat of packet
ingress_dst  in  IDX_WIDTH x N_PORTS (unpacked)  destination egress of each ingress head packet
egress_port_id  in  IDX_WIDTH  static ID of this egress
egress_ready  in  1  egress accepts beat
weight_cfg  in  WEIGHT_WIDTH x N_PORTS (unpacked)  per-ingress quota; 0 = ingress disabled
cfg_load  in  1  latch weight_cfg into internal weight registers
timeout_cycles  in  TIMEOUT_WIDTH  stall limit; 0 disables watchdog
selected_ingress  out  IDX_WIDTH  crossbar select
egress_valid  out  1  beat valid to egress
egress_last  out  1  last beat to egress
ingress_ready  out  N_PORTS  ready back to ingress, at most one bit set
grant  out  N_PORTS  registered one-hot owner, all-zero when idle
busy  out  1  state != IDLE
timeout_evt  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (sync): state IDLE, rr_ptr=0, select=0, grant=0, credit=0, stall_cnt=0, weights all 1. Outputs: egress_valid/egress_last/ingress_ready/busy/timeout_evt = 0, selected_ingress = 0. Reset mid-packet drops ownership immediately, with no egress_last.
- Eligible(i) = ingress_valid[i] && ingress_dst[i]==egress_port_id && weight[i]!=0.
- IDLE: scan i = rr_ptr, rr_ptr+1, … (IDX_WIDTH-bit add, wrap by truncation); pick the first eligible. On a find, next cycle: state SEND, select=i, grant=onehot(i), credit=weight[i]-1. Grant latency is 1 cycle. egress_valid=0 and ingress_ready=0 in IDLE.
- SEND: egress_valid=ingress_valid[select]; egress_last=ingress_valid[select]&&ingress_last[select]; ingress_ready[select]=egress_ready. Transfer = egress_valid && egress_ready.
  - Transfer with last, credit!=0: credit--, go to HOLD.
  - Transfer with last, credit==0: rr_ptr=select+1, grant=0, go to IDLE.
  - ingress_valid drop mid-packet: stall, keep ownership, no abort.
- HOLD (1 cycle, egress_valid=0): if Eligible(select), return to SEND with the same grant; else rr_ptr=select+1, grant=0, go to IDLE.
- Watchdog: stall_cnt increments in SEND when egress_ready=1 && ingress_valid[select]=0. It clears on any transfer and on leaving SEND. Egress backpressure does not count. When stall_cnt+1 == timeout_cycles (timeout_cycles!=0): timeout_evt=1 that cycle; next cycle grant=0, rr_ptr=select+1, state IDLE.
- cfg_load: weights update next cycle. A grant in the same cycle as cfg_load uses the old weights. credit of an active grant is unaffected.
- selected_ingress always equals registered select and holds its value in IDLE.

Decomposition:
- Package pkt_switch_pkg: sched_state_t enum {IDLE, SEND, HOLD} (2-bit); a shared helper constant for N_PORTS/IDX_WIDTH consistency.
- Sub-module rr_priority_pick (combinational rotating priority encoder): inputs req[N_PORTS] and ptr; outputs found and idx. Reusable by other arbiters.

Test Plan:
- Reset with all requests asserted → all outputs 0 and busy=0 during reset; first grant appears 1 cycle after release.
- Ingress 0 and 2 → dst=egress_port_id, weights 1, rr_ptr=0, 3-beat packets → grant=0001 then 0100; egress_last on beat 3; rr_ptr=3 after second packet.
- weight_cfg[1]=3 with cfg_load; ingress 1 sends 4 packets and ingress 3 requests continuously → packet order 1,1,1,3,1; one HOLD cycle between the consecutive ingress-1 packets.
- weight_cfg[2]=0 with ingress 2 requesting alone → grant stays 0 and busy=0; restore weight to 2 → grant 0100 two cycles after cfg_load.
- timeout_cycles=5; ingress 0 drops valid after beat 1 with egress_ready=1 → timeout_evt on the 5th stall cycle, IDLE next cycle, rr_ptr=1; egress_ready=0 stalls never fire the watchdog.
- Wrap and reset: rr_ptr=3, requests on 0 and 3 → grant 1000 first, then rr_ptr wraps to 0; assert reset mid-packet → grant=0 and egress_valid=0 next cycle.
